gonso_job_sequencer: RTL
========================

Name: gonso_job_sequencer

Overview:
Wishbone-mapped job scheduler for the 20-bit gonso compute core.
- Software pushes operands into an input FIFO and writes start.
- The sequencer issues one operand per cycle to the core, tracks in-flight work with a CORE_LAT-deep valid pipe, and captures results into an output FIFO.
- Software pops results from the output FIFO; irq pulses when the batch is done.
- Sits between the Wishbone slave port and the core, at base 0x30030010.

Parameters:
- CORE_LAT, 2, clock cycles from core_input change to matching core_output (1..8)
- FIFO_DEPTH, 8, entries per FIFO (power of two)
- BASE_ADDR, 32'h30030010, register block base

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- core_input  out  20  operand to core
- core_output  in  20  result from core
- irq  out  1  completion interrupt pulse

Behaviour:
- Reset values: all outputs 0; FIFOs empty; state IDLE; sticky flags 0; irq_en 0; valid pipe 0.
- Wishbone:
  - valid = cyc & stb.
  - ack is asserted the cycle after valid when ack is low, for one cycle only; each access therefore takes 2 cycles.
  - wbs_dat_o is registered with the ack.
  - Side effects (push, pop, W1C) occur once, in the ack cycle.
  - Unmapped addresses: read 0, writes ignored, still acked.
  - Write with wbs_sel_i = 0 has no effect.
- Registers (offset from BASE_ADDR):
  - 0x0 CTRL RW:
    - bit0 start: write-1 pulse, reads 0.
    - bit1 irq_en.
    - bit2 clear: write-1 pulse, reads 0.
  - 0x4 STATUS RO:
    - bit0 busy; bit1 done (sticky).
    - [7:4] in_count; [11:8] out_count.
    - bit12 in_overflow (sticky); bit13 out_underflow (sticky).
    - Writing 1 to bits 1, 12 or 13 clears that bit.
  - 0x8 IN_DATA WO: write pushes wbs_dat_i[19:0]. If the FIFO is full, the data is dropped and in_overflow is set. Reads return 0.
  - 0xC OUT_DATA RO: read returns {12'b0, head} and pops. If the FIFO is empty, returns 0 and sets out_underflow.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Start while RUN or DONE is ignored.
  - RUN, issue rule: each cycle, if the in FIFO is non-empty and (out_count + inflight) < FIFO_DEPTH:
    - pop the operand and drive it on core_input (registered);
    - shift a 1 into the valid pipe, else shift a 0.
  - RUN, capture rule: when the valid pipe tail is 1, push core_output into the out FIFO. No overflow is possible by reservation.
  - RUN -> DONE when the in FIFO is empty and inflight == 0. A start with an empty in FIFO reaches DONE after 1 RUN cycle.
  - DONE (1 cycle): set done; irq = irq_en for exactly one cycle; -> IDLE.
  - busy = (state != IDLE).
- core_input holds its last issued value when not issuing.
- Pushes during RUN are accepted and processed in the same run if they arrive before drain completes.
- Simultaneous events:
  - WB push and sequencer pop on the in FIFO in the same cycle: both happen, count unchanged.
  - WB pop and capture on the out FIFO in the same cycle: both happen.
  - W1C of done in the same cycle as the DONE state: set wins.
- clear:
  - Flushes both FIFOs, zeroes the valid pipe, forces IDLE; no done, no irq.
  - Results in flight are discarded.
  - Sticky flags are unaffected.
- rst_n asserted mid-run: immediate return to reset values; pending results are lost.

Decomposition:
- Package gonso_seq_pkg:
  - register offsets;
  - STATUS bit indices;
  - state enum {IDLE, RUN, DONE};
  - data width 20.
- Sub-module gonso_sync_fifo (WIDTH, DEPTH):
  - push/pop/full/empty/count;
  - simultaneous push+pop supported;
  - instantiated twice.
- Valid pipe and FSM live in the top level.

Test Plan:
- Bench core model y = x+1 mod 2^20, CORE_LAT = 2. Push 0x00001, 0x00002, 0xFFFFF; set irq_en; start.
  - irq pulses exactly 1 cycle; STATUS.done = 1.
  - OUT_DATA reads 0x00002, 0x00003, 0x00000; then out_count = 0.
- Push 9 operands with an empty FIFO -> in_count = 8, in_overflow = 1. Write 0x1000 to STATUS -> in_overflow = 0.
- Read OUT_DATA when empty -> data 0, out_underflow = 1, ack still 1 cycle.
- Push 8 operands, start, read no results -> 8 results captured, out_count = 8; no loss; busy falls only after the last capture.
- Start, then write clear 2 cycles later -> busy = 0 next cycle, both counts 0, done = 0, no irq.
- Start with empty FIFO and irq_en = 0 -> done = 1 within 3 cycles, irq stays 0; start while busy is ignored.

Source files
------------

// File: rtl/gonso_seq_pkg.sv
// Shared definitions for the gonso job sequencer: register map, STATUS/CTRL
// bit positions, sequencer state encoding and the core data width.
package gonso_seq_pkg;

  localparam int DATA_W = 20;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_IN_DATA  = 4'h8;
  localparam logic [3:0] OFF_OUT_DATA = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_IN_CNT  = 4;
  localparam int ST_OUT_CNT = 8;
  localparam int ST_IN_OVF  = 12;
  localparam int ST_OUT_UNF = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gonso_sync_fifo.sv
// Single-clock FIFO with show-ahead head, occupancy count and synchronous
// flush. A push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle; pops on an empty FIFO are ignored.
module gonso_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gonso_job_sequencer.sv
// Wishbone-mapped job sequencer for the 20-bit gonso core. Operands queue in
// an input FIFO, are issued one per cycle while RUN, tracked through a
// CORE_LAT-deep valid pipe, and results land in an output FIFO. Issue is
// throttled so that results already queued plus those in flight never exceed
// the output FIFO depth, which makes output overflow impossible.
module gonso_job_sequencer
  import gonso_seq_pkg::*;
#(
  parameter int          CORE_LAT   = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3003_0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] core_input,
  input  logic [DATA_W-1:0] core_output,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q;
  state_t              state_d;
  logic [CORE_LAT-1:0] vld_pipe;
  logic [7:0]          inflight;
  logic                reserve_ok;
  logic                issue;
  logic                capture;

  logic                ack_q;
  logic [31:0]         dat_q;
  logic [31:0]         rdata;
  logic                wb_acc;
  logic                wb_hit;
  logic [3:0]          wb_off;
  logic                wb_wr;
  logic                wb_rd;
  logic                wr_ctrl;
  logic                wr_status;
  logic                wr_in;
  logic                rd_out;
  logic                start_req;
  logic                clear_req;

  logic                irq_en;
  logic                irq_q;
  logic                done_flag;
  logic                in_ovf;
  logic                out_unf;
  logic                in_ovf_set;
  logic                out_unf_set;

  logic [DATA_W-1:0]   in_head;
  logic [DATA_W-1:0]   out_head;
  logic                in_full;
  logic                in_empty;
  logic                out_full;
  logic                out_empty;
  logic [CW-1:0]       in_count;
  logic [CW-1:0]       out_count;
  logic                unused_ok;

  // A new access is taken only while ack is low, so every access is two
  // cycles and all side effects fire exactly once, on the edge raising ack.
  assign wb_acc    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wb_hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wb_off    = {wbs_adr_i[3:2], 2'b00};
  assign wb_wr     = wb_acc & wbs_we_i & (|wbs_sel_i) & wb_hit;
  assign wb_rd     = wb_acc & ~wbs_we_i & wb_hit;
  assign wr_ctrl   = wb_wr & (wb_off == OFF_CTRL);
  assign wr_status = wb_wr & (wb_off == OFF_STATUS);
  assign wr_in     = wb_wr & (wb_off == OFF_IN_DATA);
  assign rd_out    = wb_rd & (wb_off == OFF_OUT_DATA);
  assign start_req = wr_ctrl & wbs_dat_i[CTRL_START];
  assign clear_req = wr_ctrl & wbs_dat_i[CTRL_CLEAR];

  assign in_ovf_set  = wr_in & in_full & ~issue;
  assign out_unf_set = rd_out & out_empty;

  assign issue      = (state_q == RUN) & ~in_empty & reserve_ok & ~clear_req;
  assign capture    = vld_pipe[CORE_LAT-1] & ~clear_req;
  assign reserve_ok = (8'(out_count) + inflight) < 8'(FIFO_DEPTH);

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;
  assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i[31:DATA_W], out_full};

  gonso_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear_req),
    .push  (wr_in),
    .din   (wbs_dat_i[DATA_W-1:0]),
    .pop   (issue),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  gonso_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear_req),
    .push  (capture),
    .din   (core_output),
    .pop   (rd_out),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // Number of results currently travelling through the core.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CORE_LAT; i++) inflight = inflight + 8'(vld_pipe[i]);
  end

  // Next-state: start only from IDLE, drain to DONE, clear overrides all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_req) state_d = RUN;
      RUN:  if (in_empty && !wr_in && inflight == 8'd0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_req) state_d = IDLE;
  end

  // Register read mux; unmapped and write-only locations read as zero.
  always_comb begin
    rdata = '0;
    if (wb_rd) begin
      case (wb_off)
        OFF_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
        OFF_STATUS: begin
          rdata[ST_BUSY]           = (state_q != IDLE);
          rdata[ST_DONE]           = done_flag;
          rdata[ST_IN_CNT +: 4]    = 4'(in_count);
          rdata[ST_OUT_CNT +: 4]   = 4'(out_count);
          rdata[ST_IN_OVF]         = in_ovf;
          rdata[ST_OUT_UNF]        = out_unf;
        end
        OFF_OUT_DATA: if (!out_empty) rdata[DATA_W-1:0] = out_head;
        default: ;
      endcase
    end
  end

  // Sequencer state, valid pipe, issued operand and completion interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_pipe   <= '0;
      core_input <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= (state_d == DONE) && irq_en;
      if (issue) core_input <= in_head;
      if (clear_req) begin
        vld_pipe <= '0;
      end else begin
        for (int i = CORE_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
        vld_pipe[0] <= issue;
      end
    end
  end

  // Bus handshake and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= wb_acc;
      dat_q <= rdata;
    end
  end

  // Control bits and sticky flags; a set in the same cycle beats a W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
      in_ovf    <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      if (state_q == DONE && !clear_req)         done_flag <= 1'b1;
      else if (wr_status && wbs_dat_i[ST_DONE])  done_flag <= 1'b0;
      if (in_ovf_set)                            in_ovf    <= 1'b1;
      else if (wr_status && wbs_dat_i[ST_IN_OVF]) in_ovf   <= 1'b0;
      if (out_unf_set)                           out_unf   <= 1'b1;
      else if (wr_status && wbs_dat_i[ST_OUT_UNF]) out_unf <= 1'b0;
    end
  end

endmodule
